// File: rtl/mem_ctrl_if.sv
// Load/store request and RAM handshake bundle for mem_ctrl.
// slave is the controller's view; master is the datapath/RAM side.
interface mem_ctrl_if;
    logic        Req;
    logic [5:0]  Opcode;
    logic [7:0]  Address;
    logic [63:0] WData;
    logic [63:0] RData;
    logic        Done;
    logic        Busy;
    logic        Trap;
    logic [1:0]  TrapType;
    logic        MFA;
    logic [5:0]  MemOpcode;
    logic [7:0]  MemAddr;
    logic [31:0] MemDataIn;
    logic [31:0] MemDataOut;
    logic        MFC;

    modport slave (
        input  Req, Opcode, Address, WData,
        input  MemDataOut, MFC,
        output RData, Done, Busy, Trap, TrapType,
        output MFA, MemOpcode, MemAddr, MemDataIn
    );

    modport master (
        output Req, Opcode, Address, WData,
        output MemDataOut, MFC,
        input  RData, Done, Busy, Trap, TrapType,
        input  MFA, MemOpcode, MemAddr, MemDataIn
    );
endinterface

// File: rtl/mem_ctrl.sv
// SPARC load/store controller driving a four-phase MFA/MFC RAM handshake.
// Doubles are split into two word accesses; loads are formatted here.
module mem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      reset,
    mem_ctrl_if.slave bus
);
    localparam logic [5:0] OP_LD   = 6'b001000;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, REQ1, REL1, REQ2, REL2, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wlo_q, wlo_d;
    logic [31:0] w0_q, w0_d;
    logic [31:0] w1_q, w1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        mfa_q, mfa_d;
    logic [5:0]  mop_q, mop_d;
    logic [7:0]  maddr_q, maddr_d;
    logic [31:0] mdin_q, mdin_d;
    logic [63:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        trap_q, trap_d;
    logic [1:0]  ttype_q, ttype_d;

    logic legal, misal, is_dbl;
    logic wait_st, moved;

    function automatic logic [63:0] fmt(
        input logic [5:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        case (op)
            OP_LDSB: fmt = {32'h0, {24{a[7]}}, a[7:0]};
            OP_LDUB: fmt = {56'h0, a[7:0]};
            OP_LDSH: fmt = {32'h0, {16{a[15]}}, a[15:0]};
            OP_LDUH: fmt = {48'h0, a[15:0]};
            OP_LD:   fmt = {32'h0, a};
            OP_LDD:  fmt = {a, b};
            default: fmt = 64'h0;
        endcase
    endfunction

    // Opcode legality first; alignment only matters for legal ops
    always_comb begin
        legal = 1'b1;
        misal = 1'b0;
        case (bus.Opcode)
            OP_LDSB, OP_LDUB, OP_STB: misal = 1'b0;
            OP_LDSH, OP_LDUH, OP_STH: misal = bus.Address[0];
            OP_LD, OP_ST:   misal = |bus.Address[1:0];
            OP_LDD, OP_STD: misal = |bus.Address[2:0];
            default:        legal = 1'b0;
        endcase
    end

    assign is_dbl = (op_q == OP_LDD) || (op_q == OP_STD);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wlo_d   = wlo_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        cnt_d   = cnt_q;
        mfa_d   = mfa_q;
        mop_d   = mop_q;
        maddr_d = maddr_q;
        mdin_d  = mdin_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        trap_d  = trap_q;
        ttype_d = ttype_q;
        wait_st = 1'b0;
        moved   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    op_d    = bus.Opcode;
                    addr_d  = bus.Address;
                    wlo_d   = bus.WData[31:0];
                    rdata_d = 64'h0;
                    trap_d  = 1'b0;
                    ttype_d = 2'b00;
                    cnt_d   = '0;
                    if (!legal) begin
                        state_d = DONE;
                        trap_d  = 1'b1;
                        ttype_d = 2'b10;
                    end else if (misal) begin
                        state_d = DONE;
                        trap_d  = 1'b1;
                        ttype_d = 2'b01;
                    end else begin
                        state_d = REQ1;
                        mfa_d   = 1'b1;
                        maddr_d = bus.Address;
                        if (bus.Opcode == OP_LDD)
                            mop_d = OP_LD;
                        else if (bus.Opcode == OP_STD)
                            mop_d = OP_ST;
                        else
                            mop_d = bus.Opcode;
                        if (bus.Opcode == OP_STD)
                            mdin_d = bus.WData[63:32];
                        else
                            mdin_d = bus.WData[31:0];
                    end
                end
            end
            REQ1, REQ2: begin
                wait_st = 1'b1;
                if (bus.MFC) begin
                    moved = 1'b1;
                    mfa_d = 1'b0;
                    cnt_d = '0;
                    if (state_q == REQ1) begin
                        w0_d    = bus.MemDataOut;
                        state_d = REL1;
                    end else begin
                        w1_d    = bus.MemDataOut;
                        state_d = REL2;
                    end
                end
            end
            REL1, REL2: begin
                wait_st = 1'b1;
                if (!bus.MFC) begin
                    moved = 1'b1;
                    cnt_d = '0;
                    if (state_q == REL1 && is_dbl) begin
                        state_d = REQ2;
                        mfa_d   = 1'b1;
                        maddr_d = addr_q + 8'd4;
                        mdin_d  = wlo_q;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        rdata_d = fmt(op_q, w0_q, w1_q);
                    end
                end
            end
            DONE: begin
                // Fault entries arrive with done_q low and pulse here
                if (done_q)
                    state_d = IDLE;
                else
                    done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (wait_st && !moved) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = DONE;
                mfa_d   = 1'b0;
                done_d  = 1'b1;
                rdata_d = 64'h0;
                trap_d  = 1'b1;
                ttype_d = 2'b11;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wlo_q   <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            cnt_q   <= '0;
            mfa_q   <= 1'b0;
            mop_q   <= '0;
            maddr_q <= '0;
            mdin_q  <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            trap_q  <= 1'b0;
            ttype_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wlo_q   <= wlo_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            cnt_q   <= cnt_d;
            mfa_q   <= mfa_d;
            mop_q   <= mop_d;
            maddr_q <= maddr_d;
            mdin_q  <= mdin_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            trap_q  <= trap_d;
            ttype_q <= ttype_d;
        end
    end

    assign bus.RData     = rdata_q;
    assign bus.Done      = done_q;
    assign bus.Busy      = busy_q;
    assign bus.Trap      = trap_q;
    assign bus.TrapType  = ttype_q;
    assign bus.MFA       = mfa_q;
    assign bus.MemOpcode = mop_q;
    assign bus.MemAddr   = maddr_q;
    assign bus.MemDataIn = mdin_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: vector table plus scoreboard, with a
// zero-delay byte RAM answering the MFA/MFC handshake.
module tb_mem_ctrl;
    localparam logic [5:0] OP_LD   = 6'b001000;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;

    typedef struct {
        logic [5:0]  op;
        logic [7:0]  addr;
        logic [63:0] wdata;
        bit          mfc;
        logic [63:0] rdata;
        bit          trap;
        logic [1:0]  tt;
        int          lat;
        int          pulses;
        int          hi;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        bit          trap;
        logic [1:0]  tt;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_ctrl_if bus();

    mem_ctrl #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       exp_q[$];
    exp_t       mon_e;
    vec_t       vt[$];
    logic [7:0] addrs[$];
    logic [7:0] mem[256];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int pulses = 0;
    int mfa_hi = 0;
    bit mfc_en = 1'b1;
    bit mfa_last = 1'b0;

    assign bus.MFC = mfc_en & bus.MFA;

    always_comb begin
        case (bus.MemOpcode)
            OP_LDSB, OP_LDUB:
                bus.MemDataOut = {24'h0, mem[bus.MemAddr]};
            OP_LDSH, OP_LDUH:
                bus.MemDataOut = {16'h0, mem[bus.MemAddr],
                                  mem[bus.MemAddr + 8'd1]};
            default:
                bus.MemDataOut = {mem[bus.MemAddr],
                                  mem[bus.MemAddr + 8'd1],
                                  mem[bus.MemAddr + 8'd2],
                                  mem[bus.MemAddr + 8'd3]};
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // RAM write side, MFA tracing and the scoreboard pop
    always @(negedge clk) begin
        if (bus.MFA && !mfa_last) begin
            pulses++;
            addrs.push_back(bus.MemAddr);
            case (bus.MemOpcode)
                OP_STB: mem[bus.MemAddr] = bus.MemDataIn[7:0];
                OP_STH: begin
                    mem[bus.MemAddr]        = bus.MemDataIn[15:8];
                    mem[bus.MemAddr + 8'd1] = bus.MemDataIn[7:0];
                end
                OP_ST: begin
                    mem[bus.MemAddr]        = bus.MemDataIn[31:24];
                    mem[bus.MemAddr + 8'd1] = bus.MemDataIn[23:16];
                    mem[bus.MemAddr + 8'd2] = bus.MemDataIn[15:8];
                    mem[bus.MemAddr + 8'd3] = bus.MemDataIn[7:0];
                end
                default: ;
            endcase
        end
        mfa_last = bus.MFA;
        if (bus.MFA) mfa_hi++;
        if (bus.Done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got Done at cycle %0d want none",
                         cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", bus.RData, mon_e.rdata);
                chk("trap", 64'(bus.Trap), 64'(mon_e.trap));
                chk("traptype", 64'(bus.TrapType), 64'(mon_e.tt));
                chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
    end

    function automatic vec_t mk(
        input logic [5:0] op, input logic [7:0] addr,
        input logic [63:0] wdata, input bit mfc,
        input logic [63:0] rdata, input bit trap,
        input logic [1:0] tt, input int lat,
        input int np, input int hi
    );
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.mfc = mfc;
        v.rdata = rdata; v.trap = trap; v.tt = tt; v.lat = lat;
        v.pulses = np; v.hi = hi;
        return v;
    endfunction

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (bus.Busy && k < 60);
        if (bus.Busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_wait: got Busy=1 want 0");
        end
    endtask

    task automatic push_exp(input logic [63:0] rd, input bit tr,
                            input logic [1:0] tt, input int acc,
                            input int lat);
        exp_t e;
        e.rdata = rd; e.trap = tr; e.tt = tt; e.acc = acc; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int d0;
        int k;
        logic [7:0] a0;
        logic [7:0] a1;
        string nm;
        nm = $sformatf("vec%0d", idx);
        wait_idle();
        mfc_en = v.mfc;
        bus.Opcode  = v.op;
        bus.Address = v.addr;
        bus.WData   = v.wdata;
        push_exp(v.rdata, v.trap, v.tt, cyc + 1, v.lat);
        pulses = 0;
        mfa_hi = 0;
        addrs.delete();
        d0 = done_cnt;
        bus.Req = 1'b1;
        @(posedge clk);
        #1 bus.Req = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (done_cnt == d0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_done: got no Done want Done", nm);
            exp_q.delete();
        end
        chk({nm, "_pulses"}, 64'(pulses), 64'(v.pulses));
        chk({nm, "_mfa_hi"}, 64'(mfa_hi), 64'(v.hi));
        a0 = (addrs.size() > 0) ? addrs[0] : 8'hxx;
        a1 = (addrs.size() > 1) ? addrs[1] : 8'hxx;
        if (v.pulses > 0) chk({nm, "_addr0"}, 64'(a0), 64'(v.addr));
        if (v.pulses > 1)
            chk({nm, "_addr1"}, 64'(a1), 64'(v.addr + 8'd4));
        mfc_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        bus.Req = 1'b0;
        bus.Opcode = '0;
        bus.Address = '0;
        bus.WData = '0;

        vt.push_back(mk(OP_ST, 8'h10, 64'hDEADBEEF, 1, 64'h0, 0, 2'b00, 2, 1, 1));
        vt.push_back(mk(OP_LD, 8'h10, 64'h0, 1, 64'hDEADBEEF, 0, 2'b00, 2, 1, 1));
        vt.push_back(mk(OP_STB, 8'h21, 64'h80, 1, 64'h0, 0, 2'b00, 2, 1, 1));
        vt.push_back(mk(OP_LDSB, 8'h21, 64'h0, 1, 64'h00000000FFFFFF80, 0, 2'b00, 2, 1, 1));
        vt.push_back(mk(OP_LDUB, 8'h21, 64'h0, 1, 64'h80, 0, 2'b00, 2, 1, 1));
        vt.push_back(mk(OP_STH, 8'h22, 64'hBEEF, 1, 64'h0, 0, 2'b00, 2, 1, 1));
        vt.push_back(mk(OP_LDSH, 8'h22, 64'h0, 1, 64'h00000000FFFFBEEF, 0, 2'b00, 2, 1, 1));
        vt.push_back(mk(OP_LDUH, 8'h22, 64'h0, 1, 64'hBEEF, 0, 2'b00, 2, 1, 1));
        vt.push_back(mk(OP_STD, 8'hF8, 64'h1122334455667788, 1, 64'h0, 0, 2'b00, 4, 2, 2));
        vt.push_back(mk(OP_LDD, 8'hF8, 64'h0, 1, 64'h1122334455667788, 0, 2'b00, 4, 2, 2));
        vt.push_back(mk(OP_LD, 8'hFC, 64'h0, 1, 64'h55667788, 0, 2'b00, 2, 1, 1));
        vt.push_back(mk(OP_LDUH, 8'h03, 64'h0, 1, 64'h0, 1, 2'b01, 1, 0, 0));
        vt.push_back(mk(6'b111111, 8'h00, 64'h0, 1, 64'h0, 1, 2'b10, 1, 0, 0));
        vt.push_back(mk(6'b000000, 8'h01, 64'h0, 1, 64'h0, 1, 2'b10, 1, 0, 0));
        vt.push_back(mk(OP_LD, 8'h02, 64'h0, 1, 64'h0, 1, 2'b01, 1, 0, 0));
        vt.push_back(mk(OP_STD, 8'h04, 64'h0, 1, 64'h0, 1, 2'b01, 1, 0, 0));
        vt.push_back(mk(OP_LDSH, 8'h05, 64'h0, 1, 64'h0, 1, 2'b01, 1, 0, 0));
        vt.push_back(mk(OP_LD, 8'h00, 64'h0, 0, 64'h0, 1, 2'b11, 16, 1, 16));
        vt.push_back(mk(OP_LD, 8'h10, 64'h0, 1, 64'hDEADBEEF, 0, 2'b00, 2, 1, 1));

        repeat (3) @(negedge clk);
        chk("rst_mfa", 64'(bus.MFA), 64'h0);
        chk("rst_done", 64'(bus.Done), 64'h0);
        chk("rst_busy", 64'(bus.Busy), 64'h0);
        chk("rst_rdata", bus.RData, 64'h0);
        chk("rst_trap", {61'h0, bus.Trap, bus.TrapType}, 64'h0);
        chk("rst_membus", {42'h0, bus.MemOpcode, bus.MemAddr, bus.MemDataIn},
            64'h0);
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

        repeat (4) @(negedge clk);
        chk("rdata_hold", bus.RData, 64'hDEADBEEF);

        // Reset while waiting in REQ1
        wait_idle();
        mfc_en = 1'b0;
        bus.Opcode = OP_LD;
        bus.Address = 8'h10;
        d0 = done_cnt;
        bus.Req = 1'b1;
        @(posedge clk);
        #1 bus.Req = 1'b0;
        chk("rq1_mfa_up", 64'(bus.MFA), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("rq1_mfa_rst", 64'(bus.MFA), 64'h0);
        chk("rq1_busy_rst", 64'(bus.Busy), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        mfc_en = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("rq1_no_done", 64'(done_cnt), 64'(d0));

        // Req pulse while Busy is dropped
        wait_idle();
        bus.Opcode = OP_LD;
        bus.Address = 8'h10;
        push_exp(64'hDEADBEEF, 0, 2'b00, cyc + 1, 2);
        d0 = done_cnt;
        bus.Req = 1'b1;
        @(posedge clk);
        #1 bus.Req = 1'b0;
        @(posedge clk);
        #1;
        bus.Opcode = 6'b111111;
        bus.Req = 1'b1;
        @(posedge clk);
        #1 bus.Req = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("busy_req_dones", 64'(done_cnt), 64'(d0 + 1));

        // Req held high back-to-back
        wait_idle();
        bus.Opcode = OP_LD;
        bus.Address = 8'h10;
        push_exp(64'hDEADBEEF, 0, 2'b00, cyc + 1, 2);
        push_exp(64'hDEADBEEF, 0, 2'b00, cyc + 5, 2);
        d0 = done_cnt;
        bus.Req = 1'b1;
        k = 0;
        while (done_cnt < d0 + 2 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        bus.Req = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("held_req_dones", 64'(done_cnt), 64'(d0 + 2));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Clocked memory access controller between the SPARC load/store datapath and the asynchronous ram_256b (MFA/MFC handshake).
- Accepts one load/store request, checks opcode and alignment, and drives a four-phase MFA/MFC handshake to the RAM.
- Splits ldd/std into two word accesses.
- Sign/zero-extends load data itself and returns a single-cycle Done with result or trap.

Parameters:
TIMEOUT, 16, clocks to wait for any MFC transition before declaring a bus error (min 2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Req  in  1  request strobe from datapath; sampled only in IDLE
Opcode  in  6  SPARC op3 load/store code
Address  in  8  byte address
WData  in  64  store data; [31:0] for st/sth/stb, [63:32]@Address and [31:0]@Address+4 for std
RData  out  64  load result; [63:32]=0 except ldd
Done  out  1  one-cycle completion pulse (with or without trap)
Busy  out  1  high whenever state != IDLE
Trap  out  1  valid with Done; request faulted
TrapType  out  2  01 misaligned, 10 illegal opcode, 11 bus timeout, 00 none
MFA  out  1  memory function active, to RAM
MemOpcode  out  6  opcode to RAM
MemAddr  out  8  address to RAM
MemDataIn  out  32  write data to RAM
MemDataOut  in  32  read data from RAM
MFC  in  1  memory function complete, from RAM

Behaviour:
- Reset (async): state IDLE; every output 0, including MFA, RData, Trap and TrapType.
- Reset mid-handshake drops MFA immediately; no partial completion is reported.
- States: IDLE, REQ1, REL1, REQ2, REL2, DONE. All outputs are registered.
- IDLE, Req=1: latch Opcode, Address and WData; decode.
  - Illegal opcode: anything other than 001000, 001001, 001010, 000001, 000010, 000011, 000101, 000110, 000100, 000111. Go to DONE with TrapType=10.
  - Misaligned: half with Address[0]!=0, word with Address[1:0]!=0, double with Address[2:0]!=0. Go to DONE with TrapType=01.
  - Illegal opcode takes priority over misaligned. MFA is never asserted for either fault.
  - Otherwise go to REQ1 and drive MFA=1, MemAddr=Address, and MemOpcode = latched opcode.
  - For ldd, MemOpcode=001000; for std, MemOpcode=000100.
  - MemDataIn = WData[31:0]; for std it is WData[63:32].
- REQ1/REQ2: hold MFA, MemOpcode, MemAddr and MemDataIn stable until MFC=1 is sampled.
  - On that edge, capture MemDataOut (loads) and clear MFA.
  - Then go to REL1/REL2.
- REL1/REL2: wait for MFC=0.
  - REL1 with a double op goes to REQ2 with MemAddr=Address+4 and MemDataIn=WData[31:0].
  - Otherwise go to DONE.
- Timeout: counter clears on entry to each REQx/RELx state.
  - Reaching TIMEOUT cycles forces MFA=0 and goes to DONE with TrapType=11.
- DONE: Done=1 for exactly one cycle, then go to IDLE.
  - RData and Trap/TrapType are held until the next accepted request.
- Load formatting:
  - ldsb: sign-extend MemDataOut[7:0]. ldub: zero-extend MemDataOut[7:0].
  - ldsh: sign-extend [15:0]. lduh: zero-extend [15:0].
  - ld: [31:0].
  - ldd: first word to RData[63:32], second to [31:0].
  - Stores and traps return RData=0.
- Latency with a zero-delay RAM, counted from the accepting edge E0:
  - Single access: Done high in cycle E2–E3.
  - Double access: Done high in cycle E4–E5.
  - Fault: Done high in cycle E1–E2.
- Req while Busy is ignored, with no queueing. Req held high continuously starts a new access on the first IDLE cycle after DONE.
- Address arithmetic is 8-bit. Aligned doubles max out at 0xF8, second access 0xFC, so no wrap is possible.

Test Plan:
- st 0xDEADBEEF at 0x10, then ld 0x10 -> MFA one pulse each; second Done has RData=0x00000000DEADBEEF; Done 2 clks after accept.
- stb 0x80 at 0x21; ldsb 0x21 -> RData=0x00000000FFFFFF80; ldub 0x21 -> 0x0000000000000080.
- std 0x1122334455667788 at 0xF8; ldd 0xF8 -> MemAddr sequence F8, FC; RData=0x1122334455667788; Done 4 clks after accept.
- lduh at 0x03 -> Done 1 clk after accept, Trap=1, TrapType=01, MFA never high; opcode 111111 -> TrapType=10.
- MFC tied 0, ld at 0x00, TIMEOUT=16 -> MFA high 16 clks then low; Done with TrapType=11; next request proceeds normally.
- Assert reset in REQ1 -> MFA=0 immediately, Done never pulses; Req during Busy ignored (single Done only).
